// File: rtl/picorv32_apb_master.sv
// PicoRV32 native memory bus to APB4 initiator: one CPU request becomes one SETUP/ACCESS transfer.
// Define APB_MASTER_TIMEOUT_EN to add a watchdog that aborts ACCESS after TIMEOUT_CYCLES waits.
module picorv32_apb_master #(
    parameter int unsigned AW             = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          mem_valid,
    input  logic          mem_instr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_ready,
    output logic [31:0]   mem_rdata,
    output logic          PSEL,
    output logic          PENABLE,
    output logic          PWRITE,
    output logic [AW-1:0] PADDR,
    output logic [31:0]   PWDATA,
    output logic [3:0]    PSTRB,
    output logic [2:0]    PPROT,
    input  logic [31:0]   PRDATA,
    input  logic          PREADY,
    input  logic          PSLVERR,
    output logic          bus_err,
    output logic [31:0]   err_addr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic [2:0]  pprot_q, pprot_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    state_d    = StSetup;
                    req_addr_d = mem_addr;
                    pwrite_d   = |mem_wstrb;
                    pwdata_d   = mem_wdata;
                    pstrb_d    = mem_wstrb;
                    pprot_d    = {mem_instr, 1'b0, 1'b1};
                    psel_d     = 1'b1;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                psel_d    = 1'b1;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = 8'd0;
`endif
            end
            StAccess: begin
                if (PREADY) begin
                    state_d     = StDone;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = (pwrite_q || PSLVERR) ? 32'h0 : PRDATA;
                    if (PSLVERR) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = req_addr_q;
                    end
                end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                    // This wait is the TIMEOUT_CYCLES-th one: abort on this edge.
                    if (cnt_q == TimeoutLast) begin
                        state_d     = StDone;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'h0;
                        bus_err_d   = 1'b1;
                        err_addr_d  = req_addr_q;
                    end else begin
                        psel_d    = 1'b1;
                        penable_d = 1'b1;
                        cnt_d     = cnt_q + 8'd1;
                    end
`else
                    psel_d    = 1'b1;
                    penable_d = 1'b1;
`endif
                end
            end
            StDone: begin
                // mem_valid deliberately ignored so the completing request is not re-issued.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            req_addr_q  <= 32'h0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'h0;
            pstrb_q     <= 4'h0;
            pprot_q     <= 3'h0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'h0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            err_addr_q  <= err_addr_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign PADDR     = {req_addr_q[AW-1:2], 2'b00};
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_picorv32_apb_master.sv
// Bench for picorv32_apb_master: each transaction is planned as a cycle timeline
// (SETUP, ACCESS run, DONE) and every cycle's outputs are compared against it.
module tb_picorv32_apb_master;

    localparam int AW   = 12;
    localparam int TO   = 4;
    localparam int MAXC = 8192;
    localparam int MAXT = 512;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          PCLK, PRESET;
    logic          mem_valid, mem_instr;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;
    logic          bus_err;
    logic [31:0]   err_addr;

    picorv32_apb_master #(.AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Timeline: role 1 = SETUP, 2 = ACCESS, 3 = DONE; rstm marks the first cycle after a reset.
    int          role [MAXC];
    int          txn  [MAXC];
    bit          rstm [MAXC];
    int          ntx = 0;
    logic [31:0] t_addr  [MAXT];
    logic [31:0] t_wdata [MAXT];
    logic [3:0]  t_wstrb [MAXT];
    logic        t_instr [MAXT];
    logic        t_err   [MAXT];
    logic [31:0] t_rdata [MAXT];

    logic          obs_psel [MAXC], obs_penable [MAXC], obs_ready [MAXC], obs_err [MAXC];
    logic          obs_pwrite [MAXC];
    logic [AW-1:0] obs_paddr [MAXC];
    logic [31:0]   obs_rdata [MAXC], obs_pwdata [MAXC], obs_err_addr [MAXC];
    logic [3:0]    obs_pstrb [MAXC];
    logic [2:0]    obs_pprot [MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    // Compare process: model state holds the fields of the last transfer and the last error.
    int            cc, rr, ii;
    logic [AW-1:0] m_paddr = '0;
    logic          m_pwrite = 1'b0;
    logic [31:0]   m_pwdata = '0, m_err_addr = '0;
    logic [3:0]    m_pstrb = '0;
    logic [2:0]    m_pprot = '0;
    logic          e_err;

    always @(negedge PCLK) begin
        cc = cyc;
        if (cc < MAXC) begin
            obs_psel[cc] = PSEL;     obs_penable[cc] = PENABLE; obs_ready[cc] = mem_ready;
            obs_err[cc] = bus_err;   obs_pwrite[cc] = PWRITE;   obs_paddr[cc] = PADDR;
            obs_rdata[cc] = mem_rdata; obs_pwdata[cc] = PWDATA; obs_err_addr[cc] = err_addr;
            obs_pstrb[cc] = PSTRB;   obs_pprot[cc] = PPROT;
            if (cc >= 2) begin
                rr = role[cc];
                ii = txn[cc];
                if (rstm[cc]) begin
                    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
                    m_pstrb = '0; m_pprot = '0;    m_err_addr = '0;
                end
                if (rr == 1) begin
                    m_paddr  = AW'(t_addr[ii] & 32'hFFFF_FFFC);
                    m_pwrite = (t_wstrb[ii] != 4'b0);
                    m_pwdata = t_wdata[ii];
                    m_pstrb  = t_wstrb[ii];
                    m_pprot  = {t_instr[ii], 2'b01};
                end
                e_err = (rr == 3) ? t_err[ii] : 1'b0;
                if (e_err) m_err_addr = t_addr[ii];
                chk("PSEL", 32'(PSEL), 32'(rr == 1 || rr == 2));
                chk("PENABLE", 32'(PENABLE), 32'(rr == 2));
                chk("mem_ready", 32'(mem_ready), 32'(rr == 3));
                chk("bus_err", 32'(bus_err), 32'(e_err));
                chk("PADDR", 32'(PADDR), 32'(m_paddr));
                chk("PWRITE", 32'(PWRITE), 32'(m_pwrite));
                chk("PWDATA", PWDATA, m_pwdata);
                chk("PSTRB", 32'(PSTRB), 32'(m_pstrb));
                chk("PPROT", 32'(PPROT), 32'(m_pprot));
                chk("err_addr", err_addr, m_err_addr);
                if (rr == 3) chk("mem_rdata", mem_rdata, t_rdata[ii]);
                else if (rstm[cc]) chk("mem_rdata_rst", mem_rdata, 32'h0);
            end
        end
    end

    task automatic rand_req();
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        mem_instr = 1'($urandom);
    endtask

    task automatic idle(input int g);
        for (int k = 0; k < g; k++) begin
            PRESET = 1'b0; mem_valid = 1'b0; rand_req();
            PRDATA = $urandom; PREADY = 1'($urandom); PSLVERR = 1'($urandom);
            @(negedge PCLK);
        end
    endtask

    // Plans one request issued in the current cycle: w wait cycles before PREADY, optional
    // reset rst_off cycles into ACCESS. Drives the CPU and slave sides through the DONE cycle.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input int w,
                           input logic slverr, input logic [31:0] rdata, input int rst_off,
                           output int a, output int dn);
        int acc_end, rc, i;
        bit to_hit;
        a       = cyc;
        to_hit  = TO_EN && (w >= TO);
        acc_end = to_hit ? a + 1 + TO : a + 2 + w;
        dn      = acc_end + 1;
        rc      = (rst_off >= 0) ? a + 2 + rst_off : -1;
        if (rc > acc_end) rc = acc_end;
        if (dn + 2 >= MAXC || ntx >= MAXT) begin
            $display("FAIL cycle_budget: got cycle %0d, want below %0d", dn, MAXC);
            $fatal(1);
        end
        i = ntx;
        ntx++;
        t_addr[i]  = addr;  t_wdata[i] = wdata; t_wstrb[i] = wstrb; t_instr[i] = instr;
        t_err[i]   = to_hit ? 1'b1 : slverr;
        t_rdata[i] = (to_hit || slverr || wstrb != 4'b0) ? 32'h0 : rdata;
        role[a + 1] = 1; txn[a + 1] = i;
        for (int c = a + 2; c <= acc_end; c++) begin role[c] = 2; txn[c] = i; end
        role[dn] = 3; txn[dn] = i;
        if (rc >= 0) begin
            for (int c = rc + 1; c <= dn; c++) role[c] = 0;
            rstm[rc + 1] = 1'b1;
            dn = rc;
        end
        for (int c = a; c <= dn; c++) begin
            if (c != a) @(negedge PCLK);
            PRESET = (c == rc);
            if (c == a) begin
                mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata;
                mem_wstrb = wstrb; mem_instr = instr;
            end else begin
                rand_req();
            end
            PRDATA  = (c == a + 2 + w) ? rdata : $urandom;
            PSLVERR = (c == a + 2 + w) ? slverr : 1'($urandom);
            if (c == a + 2 + w) PREADY = 1'b1;
            else if (c >= a + 2 && c <= acc_end) PREADY = 1'b0;
            else PREADY = 1'($urandom);
        end
    endtask

    int a, dn, a2, dn2, cnt, w, ro;
    logic [3:0] ws;
    bit slv;

    initial begin
        PRESET = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wstrb = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        rstm[2] = 1'b1; rstm[3] = 1'b1;
        repeat (3) @(negedge PCLK);
        #1;
        chk("rst_PSEL", 32'(PSEL), 32'h0);
        chk("rst_mem_ready", 32'(mem_ready), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        idle(2);

        // Zero-wait read.
        run_txn(32'h0000_0104, 32'h0, 4'b0, 1'b0, 0, 1'b0, 32'h1234_5678, -1, a, dn);
        @(negedge PCLK); #1;
        chk("d1_paddr", 32'(obs_paddr[a + 1]), 32'h104);
        chk("d1_psel", 32'(obs_psel[a + 1]), 32'h1);
        chk("d1_pen_setup", 32'(obs_penable[a + 1]), 32'h0);
        chk("d1_pen_access", 32'(obs_penable[a + 2]), 32'h1);
        chk("d1_ready_early", 32'(obs_ready[a + 2]), 32'h0);
        chk("d1_ready", 32'(obs_ready[a + 3]), 32'h1);
        chk("d1_rdata", obs_rdata[a + 3], 32'h1234_5678);
        chk("d1_err", 32'(obs_err[a + 3]), 32'h0);
        idle(1);

        // Write with three wait states.
        run_txn(32'h0000_0008, 32'hDEAD_BEEF, 4'b0011, 1'b0, 3, 1'b0, 32'hA5A5_A5A5, -1, a, dn);
        @(negedge PCLK); #1;
        for (int k = 2; k <= 5; k++) begin
            chk("d2_pwrite", 32'(obs_pwrite[a + k]), 32'h1);
            chk("d2_pstrb", 32'(obs_pstrb[a + k]), 32'h3);
            chk("d2_pwdata", obs_pwdata[a + k], 32'hDEAD_BEEF);
            chk("d2_penable", 32'(obs_penable[a + k]), 32'h1);
        end
        chk("d2_ready_early", 32'(obs_ready[a + 5]), 32'h0);
        chk("d2_ready", 32'(obs_ready[a + 6]), 32'h1);
        chk("d2_rdata", obs_rdata[a + 6], 32'h0);
        idle(1);

        // Slave error on a zero-wait read.
        run_txn(32'h0000_000C, 32'h0, 4'b0, 1'b0, 0, 1'b1, 32'h55AA_55AA, -1, a, dn);
        @(negedge PCLK); #1;
        chk("d3_ready", 32'(obs_ready[a + 3]), 32'h1);
        chk("d3_err", 32'(obs_err[a + 3]), 32'h1);
        chk("d3_rdata", obs_rdata[a + 3], 32'h0);
        chk("d3_err_addr", obs_err_addr[a + 3], 32'h0000_000C);
        idle(1);

        // Instruction fetch then back-to-back data read.
        run_txn(32'h0000_0010, 32'h0, 4'b0, 1'b1, 0, 1'b0, 32'h1111_1111, -1, a, dn);
        @(negedge PCLK);
        run_txn(32'h0000_0014, 32'h0, 4'b0, 1'b0, 0, 1'b0, 32'h2222_2222, -1, a2, dn2);
        @(negedge PCLK); #1;
        chk("d4_pprot_fetch", 32'(obs_pprot[a + 1]), 32'h5);
        chk("d4_idle_gap", 32'(obs_psel[a + 4]), 32'h0);
        chk("d4_pprot_data", 32'(obs_pprot[a2 + 1]), 32'h1);
        chk("d4_ready2", 32'(obs_ready[a2 + 3]), 32'h1);
        chk("d4_rdata2", obs_rdata[a2 + 3], 32'h2222_2222);
        idle(1);

        // One-cycle reset in the second ACCESS cycle.
        run_txn(32'h0000_0020, 32'h0, 4'b0, 1'b0, 5, 1'b0, 32'h4444_4444, 1, a, dn);
        @(negedge PCLK);
        idle(6);
        #1;
        chk("d5_psel", 32'(obs_psel[a + 4]), 32'h0);
        chk("d5_penable", 32'(obs_penable[a + 4]), 32'h0);
        chk("d5_paddr", 32'(obs_paddr[a + 4]), 32'h0);
        chk("d5_err_addr", obs_err_addr[a + 4], 32'h0);
        cnt = 0;
        for (int c = a + 4; c <= a + 9; c++) cnt += int'(obs_ready[c]);
        chk("d5_no_ready", 32'(cnt), 32'h0);

        // PREADY held low for 1000 cycles.
        run_txn(32'h0000_0030, 32'h0, 4'b0, 1'b0, 1000, 1'b0, 32'h3333_3333, -1, a, dn);
        @(negedge PCLK); #1;
        if (TO_EN) begin
            chk("d6_ready_early", 32'(obs_ready[a + 5]), 32'h0);
            chk("d6_to_ready", 32'(obs_ready[a + 6]), 32'h1);
            chk("d6_to_err", 32'(obs_err[a + 6]), 32'h1);
            chk("d6_to_rdata", obs_rdata[a + 6], 32'h0);
        end else begin
            cnt = 0;
            for (int c = a + 3; c <= a + 1002; c++) cnt += int'(obs_ready[c]);
            chk("d6_no_ready_1000", 32'(cnt), 32'h0);
            chk("d6_ready", 32'(obs_ready[a + 1003]), 32'h1);
            chk("d6_rdata", obs_rdata[a + 1003], 32'h3333_3333);
        end
        idle(1);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 7))
                                              : int'($urandom_range(0, 2));
            ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
            slv = ($urandom_range(0, 3) == 0);
            ro  = ($urandom_range(0, 19) == 0 && w >= 1) ? int'($urandom_range(0, w)) : -1;
            run_txn($urandom, $urandom, ws, 1'($urandom), w, slv, $urandom, ro, a, dn);
            @(negedge PCLK);
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
